id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core: registers decoded operands and control from the decode stage and drives the execute-stage ALU operand buses (`alu_a`, `alu_b`, `ex_alu_control`). It holds on stall, bubbles on flush, resolves EX/MEM and MEM/WB data forwarding onto the ALU operands, and flags load-use hazards for the hazard unit.

## Interface
- `W`, `` `WORD `` (32): datapath width.
- `RA`, 5: register-address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `stall` in 1: hold the ID/EX register.
- `flush` in 1: load a bubble.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_rs_data`, `id_rt_data` in W: register-file read data.
- `id_imm` in W: sign/zero-extended immediate.
- `id_rs`, `id_rt`, `id_rd` in RA: register numbers.
- `id_alu_control` in 4: ALU operation code.
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1 each: decoded control.
- `exmem_reg_write` in 1, `exmem_rd` in RA, `exmem_result` in W: EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in RA, `memwb_result` in W: MEM/WB forwarding source.
- `ex_valid` out 1: EX slot holds a real instruction.
- `alu_a`, `alu_b` out W: ALU operands.
- `ex_alu_control` out 4: registered ALU operation code.
- `ex_store_data` out W: forwarded rt value for stores.
- `ex_dest` out RA: destination register, `id_reg_dst ? id_rd : id_rt`, resolved at capture.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1 each: registered control.
- `load_use_hazard` out 1: combinational hazard request to the hazard unit.

## Operation
- Register update on each `clk` edge, priority `!rst_n` > `flush` > `stall` > load.
  - Reset: all registered fields 0, `ex_valid` = 0.
  - Flush (wins over a simultaneous stall): bubble; `ex_valid`, all control bits, `ex_alu_control`, data, register numbers and `ex_dest` all 0.
  - Stall: every field holds.
  - Load: capture all `id_*` fields; `ex_valid` <= `id_valid`.
  - `id_valid` = 0 on load: control bits are forced to 0.
- Forwarding (combinational, from registered rs/rt plus the current forwarding inputs):
  - fwd_rs = `exmem_result` if `exmem_reg_write` && `exmem_rd` != 0 && `exmem_rd` == rs.
  - Otherwise, `memwb_result` under the same condition with the MEM/WB inputs.
  - Otherwise, the registered rs data.
  - fwd_rt is formed the same way. EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- `alu_a` = fwd_rs. `alu_b` = registered `alu_src` ? registered imm : fwd_rt. `ex_store_data` = fwd_rt.
- Forwarding is re-evaluated every cycle during a stall, so held operands pick up newly arriving results.
- `load_use_hazard` = `ex_valid` & `ex_mem_read` & (`ex_dest` != 0) & `id_valid` & (`ex_dest` == `id_rs` | `ex_dest` == `id_rt`). Only the hazard unit acts on it; this block does not self-stall.
- No arithmetic in this block. All width handling is pass-through at W bits.

## Timing
- Latency: ID inputs to registered EX fields is 1 cycle.
- `alu_a`, `alu_b`, `ex_store_data` and `load_use_hazard` are combinational, valid in the same cycle as their sources. There are no combinational paths from `id_*` to `alu_a`/`alu_b`.
- Reset value of every output is 0. This includes `alu_a`/`alu_b`, provided the forwarding inputs are inactive.
- Reset asserted mid-stall or mid-flush: the next edge clears the register regardless of other inputs.
- `stall` held for N cycles: outputs are stable for N cycles, except for forwarding changes.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding as described above.
- Not defined:
  - fwd_rs and fwd_rt = registered register-file data.
  - `exmem_*`/`memwb_*` ports remain but are ignored.
  - `load_use_hazard` is unchanged; all other hazards belong to the hazard unit.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with random `id_*` -> all outputs 0. Release with `id_rs_data`=5, `id_rt_data`=7, `id_alu_src`=0, `id_valid`=1 -> next cycle `alu_a`=5, `alu_b`=7, `ex_valid`=1.
- Immediate path: `id_alu_src`=1, `id_imm`=0xFFFF_FFFC, `id_reg_dst`=0, `id_rt`=9 -> `alu_b`=0xFFFF_FFFC, `ex_dest`=9, `ex_store_data`=rt data.
- Forwarding priority (macro on): registered rs=3. EX/MEM rd=3 result=0x11 and MEM/WB rd=3 result=0x22 both writing -> `alu_a`=0x11. Drop `exmem_reg_write` -> `alu_a`=0x22. Set rd=0 on both -> registered data. Macro off: registered data in all cases.
- Stall/flush: stall 3 cycles -> outputs hold and `id_*` changes are ignored. Stall and flush together -> bubble, `ex_valid`=0, `ex_reg_write`=0, `ex_alu_control`=0.
- Load-use: EX holds lw with `ex_dest`=4, `id_rt`=4, `id_valid`=1 -> `load_use_hazard`=1. Change to `ex_dest`=0 or `id_valid`=0 -> `load_use_hazard`=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Optional feature: define ID_EX_FORWARDING_EN to forward EX/MEM and MEM/WB results onto the ALU operands.
`ifndef WORD
`define WORD 32
`endif

module id_ex_stage #(
  parameter int W  = `WORD,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [W-1:0]  id_rs_data,
  input  logic [W-1:0]  id_rt_data,
  input  logic [W-1:0]  id_imm,
  input  logic [RA-1:0] id_rs,
  input  logic [RA-1:0] id_rt,
  input  logic [RA-1:0] id_rd,
  input  logic [3:0]    id_alu_control,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RA-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RA-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_result,
  output logic          ex_valid,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    ex_alu_control,
  output logic [W-1:0]  ex_store_data,
  output logic [RA-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          load_use_hazard
);

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
    logic [RA-1:0] rs;
    logic [RA-1:0] rt;
    logic [RA-1:0] dest;
    logic [3:0]    alu_control;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_reg_t;

  ex_reg_t ex_d, ex_q;

  // A slot without a valid instruction keeps its data but must not act.
  always_comb begin
    ex_d             = '0;
    ex_d.valid       = id_valid;
    ex_d.rs_data     = id_rs_data;
    ex_d.rt_data     = id_rt_data;
    ex_d.imm         = id_imm;
    ex_d.rs          = id_rs;
    ex_d.rt          = id_rt;
    ex_d.dest        = id_reg_dst ? id_rd : id_rt;
    ex_d.alu_control = id_alu_control;
    ex_d.alu_src     = id_valid & id_alu_src;
    ex_d.reg_write   = id_valid & id_reg_write;
    ex_d.mem_read    = id_valid & id_mem_read;
    ex_d.mem_write   = id_valid & id_mem_write;
    ex_d.mem_to_reg  = id_valid & id_mem_to_reg;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n)      ex_q <= '0;
    else if (flush)  ex_q <= '0;
    else if (!stall) ex_q <= ex_d;
  end

  logic [W-1:0] fwd_rs, fwd_rt;

`ifdef ID_EX_FORWARDING_EN
  function automatic logic [W-1:0] forward(input logic [RA-1:0] r, input logic [W-1:0] reg_data);
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == r)      return exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == r) return memwb_result;
    else                                                         return reg_data;
  endfunction

  assign fwd_rs = forward(ex_q.rs, ex_q.rs_data);
  assign fwd_rt = forward(ex_q.rt, ex_q.rt_data);
`else
  // Forwarding sources are left connected but have no effect in this build.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result, ex_q.rs, ex_q.rt};
  assign fwd_rs = ex_q.rs_data;
  assign fwd_rt = ex_q.rt_data;
`endif

  assign alu_a          = fwd_rs;
  assign alu_b          = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign ex_store_data  = fwd_rt;
  assign ex_valid       = ex_q.valid;
  assign ex_alu_control = ex_q.alu_control;
  assign ex_dest        = ex_q.dest;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_mem_to_reg  = ex_q.mem_to_reg;

  assign load_use_hazard = ex_q.valid & ex_q.mem_read & (ex_q.dest != '0) & id_valid &
                           ((ex_q.dest == id_rs) | (ex_q.dest == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FORWARDING_EN when it is defined.
module tb_id_ex_stage;
  localparam int W  = 32;
  localparam int RA = 5;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, stall, flush, id_valid;
  logic [W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RA-1:0] id_rs, id_rt, id_rd;
  logic [3:0] id_alu_control;
  logic id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic exmem_reg_write, memwb_reg_write;
  logic [RA-1:0] exmem_rd, memwb_rd;
  logic [W-1:0] exmem_result, memwb_result;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;
  logic [W-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0] ex_alu_control;
  logic [RA-1:0] ex_dest;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.W(W), .RA(RA)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .ex_alu_control(ex_alu_control),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .load_use_hazard(load_use_hazard)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and checks happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_idle();
    exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic drive_id(input logic valid, input logic [W-1:0] rs_d, input logic [W-1:0] rt_d,
                          input logic [W-1:0] imm, input logic [RA-1:0] rs, input logic [RA-1:0] rt,
                          input logic [RA-1:0] rd, input logic [3:0] aluc, input logic alu_src,
                          input logic reg_dst, input logic rw, input logic mr, input logic mw,
                          input logic m2r);
    id_valid = valid; id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_control = aluc; id_alu_src = alu_src;
    id_reg_dst = reg_dst; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  initial begin
    stall = 0; flush = 0; rst_n = 0;
    fwd_idle();
    drive_id($urandom_range(0, 1), $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
             5'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
    step();
    drive_id(1, $urandom, $urandom, $urandom, 5'd7, 5'd8, 5'd9, 4'hF, 1, 1, 1, 1, 1, 1);
    step();
    check("rst_ex_valid", W'(ex_valid), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_store", ex_store_data, 0);
    check("rst_aluc", W'(ex_alu_control), 0);
    check("rst_dest", W'(ex_dest), 0);
    check("rst_ctrl", W'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 0);
    check("rst_hazard", W'(load_use_hazard), 0);

    // First real instruction after reset release.
    rst_n = 1;
    drive_id(1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 4'h2, 0, 1, 1, 0, 0, 0);
    step();
    check("rel_alu_a", alu_a, 32'd5);
    check("rel_alu_b", alu_b, 32'd7);
    check("rel_ex_valid", W'(ex_valid), 1);
    check("rel_dest_rd", W'(ex_dest), 3);
    check("rel_aluc", W'(ex_alu_control), 2);
    check("rel_reg_write", W'(ex_reg_write), 1);

    // Immediate operand, destination taken from rt.
    drive_id(1, 32'd5, 32'h77, 32'hFFFF_FFFC, 5'd1, 5'd9, 5'd3, 4'h6, 1, 0, 1, 0, 0, 0);
    step();
    check("imm_alu_b", alu_b, 32'hFFFF_FFFC);
    check("imm_dest_rt", W'(ex_dest), 9);
    check("imm_store", ex_store_data, 32'h77);
    check("imm_alu_a", alu_a, 32'd5);

    // Forwarding: registered rs=3 (0xAA), rt=5 (0xBB).
    drive_id(1, 32'hAA, 32'hBB, 32'h0, 5'd3, 5'd5, 5'd6, 4'h1, 0, 1, 1, 0, 0, 0);
    step();
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h22;
    #1 check("fwd_exmem_prio", alu_a, FWD ? 32'h11 : 32'hAA);
    check("fwd_rt_untouched", alu_b, 32'hBB);
    exmem_reg_write = 0;
    #1 check("fwd_memwb", alu_a, FWD ? 32'h22 : 32'hAA);
    exmem_reg_write = 1; exmem_rd = '0; memwb_rd = '0;
    #1 check("fwd_r0_never", alu_a, 32'hAA);
    memwb_rd = 5'd5;
    #1 check("fwd_rt_memwb", alu_b, FWD ? 32'h22 : 32'hBB);
    check("fwd_store", ex_store_data, FWD ? 32'h22 : 32'hBB);
    fwd_idle();

    // Stall for 3 cycles while the decode inputs change.
    stall = 1;
    drive_id(0, 32'h1234, 32'h5678, 32'h9, 5'd10, 5'd11, 5'd12, 4'hC, 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_alu_a", alu_a, 32'hAA);
      check("stall_alu_b", alu_b, 32'hBB);
      check("stall_valid", W'(ex_valid), 1);
      check("stall_aluc", W'(ex_alu_control), 1);
      check("stall_dest", W'(ex_dest), 6);
    end
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h33;
    #1 check("stall_fwd_rt", alu_b, FWD ? 32'h33 : 32'hBB);
    fwd_idle();

    // Flush wins over stall.
    flush = 1;
    step();
    check("flush_valid", W'(ex_valid), 0);
    check("flush_reg_write", W'(ex_reg_write), 0);
    check("flush_aluc", W'(ex_alu_control), 0);
    check("flush_alu_a", alu_a, 0);
    check("flush_dest", W'(ex_dest), 0);
    stall = 0; flush = 0;

    // Load-use: lw writing r4.
    drive_id(1, 32'h100, 32'h0, 32'h8, 5'd2, 5'd4, 5'd0, 4'h2, 1, 0, 1, 1, 0, 1);
    step();
    check("lw_mem_read", W'(ex_mem_read), 1);
    check("lw_dest", W'(ex_dest), 4);
    drive_id(1, 32'h0, 32'h0, 32'h0, 5'd6, 5'd4, 5'd7, 4'h2, 0, 1, 1, 0, 0, 0);
    #1 check("lu_rt_hit", W'(load_use_hazard), 1);
    id_valid = 0;
    #1 check("lu_id_invalid", W'(load_use_hazard), 0);
    id_valid = 1; id_rs = 5'd4; id_rt = 5'd7;
    #1 check("lu_rs_hit", W'(load_use_hazard), 1);
    id_rs = 5'd8;
    #1 check("lu_no_match", W'(load_use_hazard), 0);

    // Load to r0 never raises a hazard.
    drive_id(1, 32'h100, 32'h0, 32'h8, 5'd2, 5'd0, 5'd0, 4'h2, 1, 0, 1, 1, 0, 1);
    step();
    drive_id(1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 4'h2, 0, 1, 1, 0, 0, 0);
    #1 check("lu_dest_zero", W'(load_use_hazard), 0);

    // Invalid slot: control bits forced off.
    drive_id(0, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd3, 4'h3, 0, 1, 1, 1, 1, 1);
    step();
    check("inv_valid", W'(ex_valid), 0);
    check("inv_ctrl", W'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 0);
    check("inv_data_kept", alu_a, 32'h5);

    // Reset during stall and flush clears the register.
    drive_id(1, 32'h9, 32'hA, 32'h0, 5'd1, 5'd2, 5'd3, 4'h5, 0, 1, 1, 0, 0, 0);
    step();
    check("pre_rst_valid", W'(ex_valid), 1);
    stall = 1; flush = 1; rst_n = 0;
    step();
    check("rst_mid_valid", W'(ex_valid), 0);
    check("rst_mid_alu_a", alu_a, 0);
    check("rst_mid_aluc", W'(ex_alu_control), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
